// File: rtl/uart_to_ram_pkg.sv
// Shared definitions for the UART receive-to-RAM path.
//   BYTE_LEN           : width of one UART data byte / RAM word
//   PACKET_BUFFER_SIZE : default depth of the packet BRAM in bytes
//   TIMER_W            : width of the bit-period down counter
//   clog2()            : elaboration-time ceiling log2 for address widths
//   xfer_state_t       : transfer FSM states kept in uart_to_ram
//   rx_state_t         : byte-level receiver states kept in uart_rx_byte
// Optional build macro: UART_TO_RAM_PARITY_EN adds the RX_PARITY state (8E1 frames).
package uart_to_ram_pkg;

  localparam int BYTE_LEN           = 8;
  localparam int PACKET_BUFFER_SIZE = 2048;
  localparam int TIMER_W            = 16;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    WAIT_IDLE
  } xfer_state_t;

`ifdef UART_TO_RAM_PARITY_EN
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchroniser, bit timer and START/DATA/STOP
// sequencing (plus PARITY when UART_TO_RAM_PARITY_EN is defined, 8E1 frames).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   arm          : a falling edge on the synchronised line starts a frame only while high
//   rxd          : asynchronous UART line, idle high
//   rxd_sync     : synchronised line level
//   rx_data      : last received byte (stable after byte_valid)
//   byte_valid   : one-cycle pulse, good stop bit received
//   frame_err    : one-cycle pulse, stop bit low or parity mismatch
module uart_rx_byte
  import uart_to_ram_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                rxd,
  output logic                rxd_sync,
  output logic [BYTE_LEN-1:0] rx_data,
  output logic                byte_valid,
  output logic                frame_err
);

  localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'(CLKS_PER_BIT / 2);
  localparam logic [TIMER_W-1:0] FULL_BIT = TIMER_W'(CLKS_PER_BIT - 1);

  logic                sync_p0, sync_p1, sync_prev;
  rx_state_t           state, state_d;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic [2:0]          bit_cnt, bit_cnt_d;
  logic [BYTE_LEN-1:0] shift, shift_d;
  logic                valid_d, err_d;
  logic                fall, tick;

  assign rxd_sync = sync_p1;
  assign rx_data  = shift;
  assign fall     = sync_prev & ~sync_p1;
  assign tick     = (timer == '0);

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state)
      RX_IDLE: begin
        if (arm && fall) begin
          state_d = RX_START;
          timer_d = HALF_BIT;
        end
      end
      RX_START: begin
        if (!tick) begin
          timer_d = timer - 1'b1;
        end else if (!sync_p1) begin
          state_d   = RX_DATA;
          timer_d   = FULL_BIT;
          bit_cnt_d = '0;
        end else begin
          // line back high at mid start bit: glitch, re-arm
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!tick) begin
          timer_d = timer - 1'b1;
        end else begin
          shift_d   = {sync_p1, shift[BYTE_LEN-1:1]};
          timer_d   = FULL_BIT;
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TO_RAM_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_TO_RAM_PARITY_EN
      RX_PARITY: begin
        if (!tick) begin
          timer_d = timer - 1'b1;
        end else if (sync_p1 != (^shift)) begin
          err_d   = 1'b1;
          state_d = RX_IDLE;
        end else begin
          timer_d = FULL_BIT;
          state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (!tick) begin
          timer_d = timer - 1'b1;
        end else begin
          valid_d = sync_p1;
          err_d   = ~sync_p1;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // stage p0/p1: line synchroniser and control registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      sync_prev  <= 1'b1;
      state      <= RX_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_p0    <= rxd;
      sync_p1    <= sync_p0;
      sync_prev  <= sync_p1;
      state      <= state_d;
      timer      <= timer_d;
      bit_cnt    <= bit_cnt_d;
      byte_valid <= valid_d;
      frame_err  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_d;
  end

endmodule

// File: rtl/uart_to_ram.sv
// Receives UART bytes from the host and writes them to packet BRAM at
// consecutive addresses, wrapping modulo 2^AW.
// Optional build macro: UART_TO_RAM_PARITY_EN selects 8E1 framing (default 8N1).
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   start                 : pulse, arms a transfer (ignored while busy)
//   write_start/write_end : first address / one past last (equal = full buffer)
//   rxd                   : asynchronous UART line
//   ram_write_enable/addr/val : bram_driver write port
//   busy, done            : transfer in progress / last byte written pulse
//   frame_err             : sticky framing or parity error, cleared on start
module uart_to_ram
  import uart_to_ram_pkg::*;
#(
  parameter  int RAM_SIZE = PACKET_BUFFER_SIZE,
  parameter  int CLK_FREQ = 50000000,
  parameter  int BAUD     = 115200,
  localparam int AW       = clog2(RAM_SIZE)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [AW-1:0]       write_start,
  input  logic [AW-1:0]       write_end,
  input  logic                rxd,
  output logic                ram_write_enable,
  output logic [AW-1:0]       ram_write_addr,
  output logic [BYTE_LEN-1:0] ram_write_val,
  output logic                busy,
  output logic                done,
  output logic                frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  xfer_state_t         state, state_d;
  logic [AW-1:0]       curr_addr, end_addr, addr_d, next_addr;
  logic                rxd_sync, byte_valid, rx_err, err_set;
  logic [BYTE_LEN-1:0] rx_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .arm       (state == WAIT_START),
    .rxd       (rxd),
    .rxd_sync  (rxd_sync),
    .rx_data   (rx_data),
    .byte_valid(byte_valid),
    .frame_err (rx_err)
  );

  assign next_addr      = curr_addr + AW'(1);
  assign busy           = (state != IDLE);
  assign ram_write_addr = curr_addr;
  assign ram_write_val  = ram_write_enable ? rx_data : '0;

  always_comb begin
    state_d          = state;
    addr_d           = curr_addr;
    ram_write_enable = 1'b0;
    done             = 1'b0;
    err_set          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (byte_valid) begin
          ram_write_enable = 1'b1;
          addr_d           = next_addr;
          // compared after increment so write_start == write_end covers the whole RAM
          if (next_addr == end_addr) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end else if (rx_err) begin
          err_set = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxd_sync) state_d = WAIT_START;
      end
      default: state_d = IDLE;
    endcase
  end

  // stage p0: transfer state, address and sticky error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      curr_addr <= '0;
      end_addr  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      curr_addr <= addr_d;
      if (state == IDLE && start) begin
        curr_addr <= write_start;
        end_addr  <= write_end;
        frame_err <= 1'b0;
      end else if (err_set) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_to_ram.md
Name: uart_to_ram

Overview:
- Receive direction of the UART debug path: samples the board UART TX line from the host, deserialises 8N1 bytes and writes them into packet BRAM at consecutive addresses.
- Write port connects directly to bram_driver (write_enable/write_addr/write_val).
- Used to preload packet buffers from the host and read them back with the existing RAM-to-UART dump.

Parameters:
- RAM_SIZE, PACKET_BUFFER_SIZE: depth of the target RAM in bytes. Address width is AW = clog2(RAM_SIZE).
- CLK_FREQ, 50000000: clk frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 434 at the defaults).

Ports:
- clk  in  1  system clock (50 MHz domain).
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; arms a transfer. Ignored while busy.
- write_start  in  AW  first RAM address, sampled on start.
- write_end  in  AW  one past the last address, sampled on start. Compared modulo 2^AW.
- rxd  in  1  asynchronous UART line, idle high.
- ram_write_enable  out  1  one-cycle write strobe.
- ram_write_addr  out  AW  write address, valid with the strobe.
- ram_write_val  out  BYTE_LEN  received byte, valid with the strobe.
- busy  out  1  high from the cycle after start until the cycle done pulses.
- done  out  1  one-cycle pulse when the last byte has been written.
- frame_err  out  1  sticky flag: a stop bit was sampled low (or a parity mismatch, see Optional Feature). Cleared on start.

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0, FSM to IDLE, synchroniser flops set to 1.
- Reset mid-byte aborts the transfer. Nothing more is written; busy drops the next cycle.
- rxd passes through a 2-flop synchroniser before use. Edge detection and sampling use the synchronised value only.
- FSM states: IDLE, WAIT_START, START_BIT, DATA, STOP_BIT, WAIT_IDLE.
  - IDLE: on start, latch curr_addr=write_start and end_addr=write_end, clear frame_err, then go to WAIT_START.
  - WAIT_START: a high-to-low transition of the synchronised rxd loads the bit counter with CLKS_PER_BIT/2, then START_BIT.
  - START_BIT: at the half-bit point, if rxd is still 0, go to DATA. Otherwise treat it as a glitch and return to WAIT_START.
  - DATA: 8 samples spaced CLKS_PER_BIT apart, at bit centres, shifted in LSB first. Then STOP_BIT.
  - STOP_BIT: sampled one CLKS_PER_BIT after the last data sample.
    - Stop bit = 1: ram_write_enable=1 for exactly that cycle, with ram_write_addr=curr_addr and ram_write_val=the byte. curr_addr increments modulo 2^AW. If the incremented value equals end_addr, pulse done and go to IDLE; otherwise go to WAIT_START.
    - Stop bit = 0: set frame_err, skip the write, leave curr_addr unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: wait for the synchronised rxd = 1, then WAIT_START.
- Latency: write strobe occurs 2 (synchroniser) + 9.5*CLKS_PER_BIT cycles after the falling edge of the start bit.
- write_start == write_end means a full buffer: RAM_SIZE bytes, wrapping through address 0. This matches the write_end=RAM_SIZE idiom with an AW-bit port.
- Address wraps from 2^AW-1 to 0 silently.
- start while busy has no effect. start and a falling rxd edge in the same IDLE cycle: the edge is not counted.
- A continuously low line (break) gives a frame error on the first byte, then the FSM holds in WAIT_IDLE.

Optional Feature:
- Macro UART_TO_RAM_PARITY_EN.
- Defined: frame is 8E1. An even-parity bit is sampled between data bit 7 and the stop bit. On a parity mismatch the byte is discarded, frame_err is set, and the FSM goes to WAIT_IDLE. Adds a PARITY state.
- Undefined: 8N1 only, no PARITY state, no parity logic.

Decomposition:
- params.vh: BYTE_LEN, PACKET_BUFFER_SIZE, clog2, and the state encodings as localparams.
- Sub-module uart_rx_byte: synchroniser, bit timer, START/DATA/STOP(/PARITY) sequencing. Outputs byte, byte_valid pulse, frame_err pulse; also used standalone.
- uart_to_ram keeps the address and transfer FSM (IDLE/WAIT_START/WAIT_IDLE and the end compare).

Test Plan:
- write_start=0x010, write_end=0x013, send 0xA5, 0x3C, 0xFF at 115200 baud → writes (0x010,A5), (0x011,3C), (0x012,FF); done pulses once, in the cycle of the third strobe; busy falls the next cycle; frame_err=0.
- Send 0x55 with the stop bit forced low, then 0x12 → no write for 0x55; frame_err=1; 0x12 written at write_start; frame_err stays 1.
- 100-cycle low glitch on rxd in WAIT_START → no write, FSM back in WAIT_START; the next valid byte 0x7E is written correctly.
- write_start=write_end=RAM_SIZE-2 with RAM_SIZE=2048 → writes to 2046, 2047, 0, …, done after the 2048th byte; no early done.
- reset_n low for 1 cycle mid-DATA of byte 0x81 → no strobe; busy=0, done=0, frame_err=0; a new start works normally.
- UART_TO_RAM_PARITY_EN defined, send 0x03 with parity bit 1 (wrong) then 0x03 with parity bit 0 → first byte discarded with frame_err=1; second byte written.
